key_cmd_gen: RTL and testbench



---
 rtl/key_cmd_gen.sv | 173 +++++++++++++++++
 tb/tb_key_cmd_gen.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/key_cmd_gen.sv
// key_cmd_gen: per-frame HID keycode sampler producing game commands with
// DAS/ARR auto-repeat for LEFT/RIGHT/DOWN and a priority valid/ready command port.
// Optional build macro: KEY_ARROWS_EN maps arrow keys alongside the letter keys.
module key_cmd_gen #(
    parameter int unsigned NUM_KEYS   = 4,
    parameter int unsigned DAS_FRAMES = 10,
    parameter int unsigned ARR_FRAMES = 2
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    frame_tick,
    input  logic [8*NUM_KEYS-1:0]   keycode,
    input  logic                    cmd_ready,
    output logic                    cmd_valid,
    output logic [2:0]              cmd,
    output logic [5:0]              held
);

    localparam int unsigned MAX_FRAMES = (DAS_FRAMES > ARR_FRAMES) ? DAS_FRAMES : ARR_FRAMES;
    localparam int unsigned TW         = $clog2(MAX_FRAMES + 1);
    localparam logic [TW-1:0] DAS_LOAD = TW'(DAS_FRAMES);
    localparam logic [TW-1:0] ARR_LOAD = TW'(ARR_FRAMES);

    localparam int unsigned C_LEFT  = 0;
    localparam int unsigned C_RIGHT = 1;
    localparam int unsigned C_DOWN  = 2;
    localparam int unsigned C_ROTL  = 3;
    localparam int unsigned C_ROTR  = 4;
    localparam int unsigned C_HARD  = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } rep_state_t;

    rep_state_t       state [3];
    logic [TW-1:0]    timer [3];
    logic [5:0]       pending;
    logic [5:0]       raw;
    logic [5:0]       sample;
    logic [5:0]       set_req;
    logic [5:0]       clr_req;
    logic [7:0]       code;
    logic [2:0]       next_cmd;

    // Decode every key slot into a raw per-command held vector
    always_comb begin
        raw  = '0;
        code = '0;
        for (int i = 0; i < int'(NUM_KEYS); i++) begin
            code = keycode[8*i +: 8];
            case (code)
                8'h04: raw[C_LEFT]  = 1'b1;
                8'h07: raw[C_RIGHT] = 1'b1;
                8'h16: raw[C_DOWN]  = 1'b1;
                8'h14: raw[C_ROTL]  = 1'b1;
                8'h1A: raw[C_ROTR]  = 1'b1;
                8'h2C: raw[C_HARD]  = 1'b1;
`ifdef KEY_ARROWS_EN
                8'h50: raw[C_LEFT]  = 1'b1;
                8'h4F: raw[C_RIGHT] = 1'b1;
                8'h51: raw[C_DOWN]  = 1'b1;
                8'h52: raw[C_ROTR]  = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    // Opposing horizontal keys cancel each other out
    always_comb begin
        sample = raw;
        if (raw[C_LEFT] && raw[C_RIGHT]) begin
            sample[C_LEFT]  = 1'b0;
            sample[C_RIGHT] = 1'b0;
        end
    end

    // Pending-set requests: press/DAS/ARR expiry for repeatables, rising edge otherwise
    always_comb begin
        set_req = '0;
        for (int k = 0; k < 3; k++) begin
            if (frame_tick && sample[k]) begin
                case (state[k])
                    ST_IDLE: set_req[k] = 1'b1;
                    default: set_req[k] = (timer[k] <= TW'(1));
                endcase
            end
        end
        for (int k = 3; k < 6; k++) begin
            set_req[k] = frame_tick && sample[k] && !held[k];
        end
    end

    // Accepted command clears its pending bit, overriding a same-edge set
    always_comb begin
        clr_req = '0;
        if (cmd_valid && cmd_ready) begin
            clr_req = 6'(1) << cmd;
        end
    end

    // Fixed priority: HARD_DROP > ROT_R > ROT_L > LEFT > RIGHT > DOWN
    always_comb begin
        next_cmd = 3'(C_LEFT);
        if      (pending[C_HARD])  next_cmd = 3'(C_HARD);
        else if (pending[C_ROTR])  next_cmd = 3'(C_ROTR);
        else if (pending[C_ROTL])  next_cmd = 3'(C_ROTL);
        else if (pending[C_LEFT])  next_cmd = 3'(C_LEFT);
        else if (pending[C_RIGHT]) next_cmd = 3'(C_RIGHT);
        else if (pending[C_DOWN])  next_cmd = 3'(C_DOWN);
    end

    // Frame-rate DAS/ARR state machines, held sample and pending bits
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int k = 0; k < 3; k++) begin
                state[k] <= ST_IDLE;
                timer[k] <= '0;
            end
            held    <= '0;
            pending <= '0;
        end else begin
            if (frame_tick) begin
                held <= sample;
                for (int k = 0; k < 3; k++) begin
                    if (!sample[k]) begin
                        state[k] <= ST_IDLE;
                        timer[k] <= '0;
                    end else begin
                        case (state[k])
                            ST_IDLE: begin
                                state[k] <= ST_DELAY;
                                timer[k] <= DAS_LOAD;
                            end
                            ST_DELAY: begin
                                if (timer[k] <= TW'(1)) begin
                                    state[k] <= ST_REPEAT;
                                    timer[k] <= ARR_LOAD;
                                end else begin
                                    timer[k] <= timer[k] - TW'(1);
                                end
                            end
                            default: begin
                                if (timer[k] <= TW'(1)) begin
                                    timer[k] <= ARR_LOAD;
                                end else begin
                                    timer[k] <= timer[k] - TW'(1);
                                end
                            end
                        endcase
                    end
                end
            end
            pending <= (pending | set_req) & ~clr_req;
        end
    end

    // Command port: load highest pending when idle, hold until accepted
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cmd_valid <= 1'b0;
            cmd       <= '0;
        end else if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
        end else if (!cmd_valid && (pending != '0)) begin
            cmd_valid <= 1'b1;
            cmd       <= next_cmd;
        end
    end

endmodule

// File: tb/tb_key_cmd_gen.sv
// Scoreboard bench for key_cmd_gen (default parameters NUM_KEYS=4, DAS=10, ARR=2).
module tb_key_cmd_gen;

    localparam int unsigned DAS = 10;
    localparam int unsigned ARR = 2;
    localparam int unsigned GAP = 7;

    logic        Clk;
    logic        Reset;
    logic        frame_tick;
    logic [31:0] keycode;
    logic        cmd_ready;
    logic        cmd_valid;
    logic [2:0]  cmd;
    logic [5:0]  held;

    int n_checks;
    int n_fail;

    logic [2:0] exp_q [$];
    logic [2:0] exp_cmd;
    logic       prev_offer;
    logic [2:0] prev_cmd;

    key_cmd_gen dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .keycode    (keycode),
        .cmd_ready  (cmd_ready),
        .cmd_valid  (cmd_valid),
        .cmd        (cmd),
        .held       (held)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One-cycle frame pulse sampling kc; returns #1 after the sampling edge
    task automatic do_tick(input logic [31:0] kc);
        keycode    = kc;
        frame_tick = 1'b1;
        @(posedge Clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Transfer monitor: each accepted command must match the scoreboard head
    always @(negedge Clk) begin
        if (Reset) begin
            prev_offer = 1'b0;
        end else begin
            if (prev_offer) check("cmd_stable", 32'(cmd), 32'(prev_cmd));
            if (cmd_valid && cmd_ready) begin
                if (exp_q.size() == 0) begin
                    // 7 is not a command code: nothing was expected here
                    check("extra_cmd", 32'(cmd), 32'd7);
                end else begin
                    exp_cmd = exp_q.pop_front();
                    check("cmd", 32'(cmd), 32'(exp_cmd));
                end
            end
            prev_offer = cmd_valid && !cmd_ready;
            prev_cmd   = cmd;
        end
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        prev_offer = 1'b0;
        prev_cmd   = '0;
        Reset      = 1'b1;
        frame_tick = 1'b0;
        keycode    = '0;
        cmd_ready  = 1'b0;
        idle(3);
        check("rst_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd", 32'(cmd), 32'd0);
        check("rst_held", 32'(held), 32'd0);
        Reset = 1'b0;
        idle(2);

        // Held A for 25 ticks: press, then repeats at DAS and every ARR after
        cmd_ready = 1'b1;
        for (int t = 0; t < 25; t++) begin
            if (t == 0 || (t >= int'(DAS) && ((t - int'(DAS)) % int'(ARR)) == 0))
                exp_q.push_back(3'd0);
            do_tick(32'h0000_0004);
            if (t == 0) begin
                check("lat_e0_valid", 32'(cmd_valid), 32'd0);
                check("held_left", 32'(held), 32'h01);
                idle(1);
                check("lat_e1_valid", 32'(cmd_valid), 32'd1);
                check("lat_e1_cmd", 32'(cmd), 32'd0);
                idle(GAP - 1);
            end else begin
                idle(GAP);
            end
        end
        do_tick(32'h0);
        idle(GAP);
        check("das_drain", 32'(exp_q.size()), 32'd0);

        // Single-tick W+space with ready low: HARD_DROP offered and held, then ROT_R
        cmd_ready = 1'b0;
        exp_q.push_back(3'd5);
        exp_q.push_back(3'd4);
        do_tick(32'h001A_2C00);
        keycode = 32'h0;
        idle(20);
        check("offer_valid", 32'(cmd_valid), 32'd1);
        check("offer_cmd", 32'(cmd), 32'd5);
        check("held_rot_hd", 32'(held), 32'h30);
        cmd_ready = 1'b1;
        idle(10);
        do_tick(32'h0);
        idle(GAP);
        check("prio_drain", 32'(exp_q.size()), 32'd0);

        // A and D together cancel: nothing issued, held[1:0] stays clear
        for (int t = 0; t < 30; t++) begin
            do_tick(32'h0000_0704);
            if (t == 0) check("lr_held", 32'(held[1:0]), 32'd0);
            idle(GAP);
        end
        check("lr_cmd_none", 32'(cmd_valid), 32'd0);
        do_tick(32'h0);
        idle(GAP);

        // Tap S with ready low for 100 cycles: exactly one DOWN afterwards
        cmd_ready = 1'b0;
        exp_q.push_back(3'd2);
        do_tick(32'h0000_0016);
        idle(GAP);
        do_tick(32'h0);
        idle(100);
        check("tap_offer_cmd", 32'(cmd), 32'd2);
        cmd_ready = 1'b1;
        idle(10);
        check("tap_drain", 32'(exp_q.size()), 32'd0);

        // Reset while a command is offered clears the offer and pending state
        cmd_ready = 1'b0;
        do_tick(32'h0000_0004);
        keycode = 32'h0;
        for (int i = 0; i < 20 && !cmd_valid; i++) idle(1);
        check("pre_rst_valid", 32'(cmd_valid), 32'd1);
        Reset = 1'b1;
        idle(1);
        check("mid_rst_valid", 32'(cmd_valid), 32'd0);
        check("mid_rst_held", 32'(held), 32'd0);
        Reset     = 1'b0;
        cmd_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            do_tick(32'h0);
            idle(GAP);
        end
        check("post_rst_valid", 32'(cmd_valid), 32'd0);

        // Arrow keys: mapped only when KEY_ARROWS_EN is defined
`ifdef KEY_ARROWS_EN
        exp_q.push_back(3'd0);
        do_tick(32'h0000_0050);
        check("arrow_held", 32'(held), 32'h01);
        idle(GAP);
        do_tick(32'h0);
        idle(GAP);
`else
        for (int t = 0; t < 20; t++) begin
            do_tick(32'h5251_4F50);
            if (t == 0) check("arrow_held", 32'(held), 32'h00);
            idle(GAP);
        end
        do_tick(32'h0);
        idle(GAP);
`endif
        check("final_drain", 32'(exp_q.size()), 32'd0);
        check("final_valid", 32'(cmd_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
